cpm_fifo_rd_unpack: RTL and testbench

- Read-side companion to the CPM FIFO.
- Drains wide FIFO words and serialises them LSB-subword-first onto a narrow valid/ready stream.
- Drives the FIFO pop interface, which has a registered read port with 1-cycle latency.
- Transfers a programmed number of subwords per start command, then pulses done. Sits between the CPM buffer and downstream narrow consumers.

---
 rtl/cpm_rd_pkg.sv | 21 ++
 rtl/cpm_fifo_rd_unpack.sv | 112 +++++++++++
 tb/tb_cpm_fifo_rd_unpack.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpm_rd_pkg.sv
// rtl/cpm_rd_pkg.sv - shared state encoding and geometry helpers for the CPM FIFO read unpacker
package cpm_rd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_POP  = 3'd1,
      ST_LOAD = 3'd2,
      ST_SEND = 3'd3,
      ST_DONE = 3'd4
   } rd_state_t;

   function automatic int calc_ratio(input int fifo_width, input int out_width);
      return fifo_width / out_width;
   endfunction

   // A single-subword word still needs a 1-bit index to keep the vectors legal.
   function automatic int calc_idx_width(input int ratio);
      return (ratio > 1) ? $clog2(ratio) : 1;
   endfunction

endpackage

// File: rtl/cpm_fifo_rd_unpack.sv
// rtl/cpm_fifo_rd_unpack.sv - pops wide CPM FIFO words and streams them LSB-subword-first
module cpm_fifo_rd_unpack
   import cpm_rd_pkg::*;
#(
   parameter int FIFO_WIDTH = 64,
   parameter int OUT_WIDTH  = 16,
   parameter int LEN_WIDTH  = 12
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  Reset,
   input  logic                  start,
   input  logic [LEN_WIDTH-1:0]  cfg_len,
   output logic                  busy,
   output logic                  done,
   input  logic                  fifo_empty,
   output logic                  fifo_pop,
   input  logic [FIFO_WIDTH-1:0] fifo_data_out,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [OUT_WIDTH-1:0]  out_data,
   output logic                  out_last
);

   localparam int RATIO     = calc_ratio(FIFO_WIDTH, OUT_WIDTH);
   localparam int IDX_WIDTH = calc_idx_width(RATIO);
   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(RATIO - 1);

   rd_state_t             state;
   rd_state_t             state_nxt;
   logic [FIFO_WIDTH-1:0] word_buf;
   logic [LEN_WIDTH-1:0]  remaining;
   logic [IDX_WIDTH-1:0]  sub_idx;
   logic [OUT_WIDTH-1:0]  subword [RATIO];
   logic                  last_sub;

   for (genvar g = 0; g < RATIO; g++) begin : g_split
      assign subword[g] = word_buf[g*OUT_WIDTH +: OUT_WIDTH];
   end

   assign last_sub = (remaining == LEN_WIDTH'(1));

   always_comb begin
      state_nxt = state;
      busy      = (state != ST_IDLE);
      done      = 1'b0;
      fifo_pop  = 1'b0;
      out_valid = 1'b0;
      out_data  = '0;
      out_last  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) state_nxt = (cfg_len != '0) ? ST_POP : ST_DONE;
         end
         ST_POP: begin
            if (!fifo_empty) begin
               fifo_pop  = 1'b1;
               state_nxt = ST_LOAD;
            end
         end
         ST_LOAD: state_nxt = ST_SEND;
         ST_SEND: begin
            out_valid = 1'b1;
            out_data  = subword[sub_idx];
            out_last  = last_sub;
            if (out_ready) begin
               if (last_sub)                state_nxt = ST_DONE;
               else if (sub_idx == LAST_IDX) state_nxt = ST_POP;
            end
         end
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Both reset forms abandon the transfer outright; a popped word is simply lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         word_buf  <= '0;
         remaining <= '0;
         sub_idx   <= '0;
      end else if (Reset) begin
         state     <= ST_IDLE;
         word_buf  <= '0;
         remaining <= '0;
         sub_idx   <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  remaining <= cfg_len;
                  sub_idx   <= '0;
               end
            end
            ST_LOAD: word_buf <= fifo_data_out;
            ST_SEND: begin
               if (out_ready) begin
                  remaining <= remaining - LEN_WIDTH'(1);
                  sub_idx   <= (sub_idx == LAST_IDX) ? '0 : sub_idx + IDX_WIDTH'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cpm_fifo_rd_unpack.sv
// tb/tb_cpm_fifo_rd_unpack.sv - self-checking bench for the CPM FIFO read unpacker
module tb_cpm_fifo_rd_unpack;

   localparam int FW    = 64;
   localparam int OW    = 16;
   localparam int LW    = 12;
   localparam int RATIO = FW / OW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          Reset = 1'b0;
   logic          start = 1'b0;
   logic [LW-1:0] cfg_len = '0;
   logic          busy, done, fifo_pop, out_valid, out_last;
   logic [OW-1:0] out_data;
   logic          fifo_empty = 1'b1;
   logic [FW-1:0] fifo_data_out = '0;
   logic          out_ready = 1'b0;

   cpm_fifo_rd_unpack #(.FIFO_WIDTH(FW), .OUT_WIDTH(OW), .LEN_WIDTH(LW)) dut (
      .clk(clk), .rst_n(rst_n), .Reset(Reset), .start(start), .cfg_len(cfg_len),
      .busy(busy), .done(done), .fifo_empty(fifo_empty), .fifo_pop(fifo_pop),
      .fifo_data_out(fifo_data_out), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural FIFO source with a registered read port.
   logic [FW-1:0] fifo_q[$];
   logic [FW-1:0] pushed[$];
   logic          push_req = 1'b0;
   logic          fifo_clr = 1'b0;
   logic [FW-1:0] push_val = '0;
   always @(posedge clk) begin
      if (fifo_clr) fifo_q.delete();
      else begin
         if (fifo_pop && fifo_q.size() > 0) fifo_data_out <= fifo_q.pop_front();
         if (push_req) fifo_q.push_back(push_val);
      end
      fifo_empty <= (fifo_q.size() == 0);
   end

   logic          mon_clr = 1'b0;
   int            start_cyc = 0;
   logic [OW-1:0] got_data[$];
   logic          got_last[$];
   int            got_rel[$];
   int            pop_cnt = 0, bad_pop = 0, done_cnt = 0, done_rel = -1;
   int            first_pop = -1, first_valid = -1, stab_err = 0, rel = 0;
   logic          hold_prev = 1'b0;
   logic [OW-1:0] prev_data = '0;
   logic          prev_last = 1'b0;
   always @(negedge clk) begin
      if (mon_clr) begin
         got_data.delete(); got_last.delete(); got_rel.delete();
         pop_cnt = 0; bad_pop = 0; done_cnt = 0; done_rel = -1;
         first_pop = -1; first_valid = -1; stab_err = 0; hold_prev = 1'b0;
      end else begin
         rel = cyc - start_cyc;
         if (out_valid && out_ready) begin
            got_data.push_back(out_data);
            got_last.push_back(out_last);
            got_rel.push_back(rel);
         end
         if (fifo_pop) begin
            pop_cnt++;
            if (first_pop < 0) first_pop = rel;
         end
         if (fifo_pop && fifo_empty) bad_pop++;
         if (done) begin
            done_cnt++;
            done_rel = rel;
         end
         if (out_valid && first_valid < 0) first_valid = rel;
         if (hold_prev && !(out_valid && out_data == prev_data && out_last == prev_last)) stab_err++;
         hold_prev = out_valid && !out_ready;
         prev_data = out_data;
         prev_last = out_last;
      end
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic rdy(input int mode, input int k);
      if (mode == 0) return 1'b1;
      if (mode == 1) return (k % 3) == 0;
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic push_word(input logic [FW-1:0] w);
      push_req = 1'b1;
      push_val = w;
      pushed.push_back(w);
      tick();
      push_req = 1'b0;
   endtask

   task automatic flush();
      fifo_clr = 1'b1;
      pushed.delete();
      tick();
      fifo_clr = 1'b0;
      tick();
   endtask

   function automatic logic [FW-1:0] seq_word(input int j);
      return {OW'(4*j+4), OW'(4*j+3), OW'(4*j+2), OW'(4*j+1)};
   endfunction

   task automatic start_xfer(input int len);
      mon_clr = 1'b1;
      @(negedge clk);
      #1;
      mon_clr = 1'b0;
      tick();
      start_cyc = cyc;
      start = 1'b1;
      cfg_len = LW'(len);
      tick();
      start = 1'b0;
      cfg_len = LW'($urandom);
   endtask

   task automatic finish_xfer(input int mode, input int budget, input bit poke);
      int k;
      k = 1;
      out_ready = rdy(mode, k);
      while (done_cnt == 0 && k < budget) begin
         tick();
         k++;
         if (poke && k == 5) begin
            start = 1'b1;
            cfg_len = LW'(1);
         end
         if (poke && k == 6) start = 1'b0;
         out_ready = rdy(mode, k);
      end
      start = 1'b0;
      tick();
      tick();
      check("done_pulse_count", done_cnt, 1);
   endtask

   // Reference: subword i is slice (i mod RATIO) of pushed word i/RATIO; with
   // out_ready held high subword i appears at base + i + 2*(i/RATIO).
   task automatic check_stream(input int len, input int base, input string tag);
      int nw;
      logic [FW-1:0] w;
      logic [OW-1:0] e;
      nw = (len + RATIO - 1) / RATIO;
      check({tag, "_count"}, got_data.size(), len);
      for (int i = 0; i < len && i < got_data.size(); i++) begin
         w = pushed[i / RATIO];
         e = OW'(w >> (OW * (i % RATIO)));
         check({tag, "_data"}, got_data[i], e);
         check({tag, "_last"}, got_last[i], (i == len - 1));
         if (base >= 0) check({tag, "_cycle"}, got_rel[i], base + i + 2 * (i / RATIO));
      end
      check({tag, "_pops"}, pop_cnt, nw);
      check({tag, "_pop_on_empty"}, bad_pop, 0);
      check({tag, "_stable"}, stab_err, 0);
      check({tag, "_fifo_left"}, fifo_q.size(), pushed.size() - nw);
   endtask

   typedef struct {
      int len;
      int nwords;
      int exp_pops;
      int exp_done;
   } vec_t;
   vec_t vecs[7];

   initial begin
      int len, nw, k, ne_rel;
      vecs[0] = '{0, 0, 0, 1};
      vecs[1] = '{1, 1, 1, 4};
      vecs[2] = '{4, 1, 1, 7};
      vecs[3] = '{3, 2, 1, 6};
      vecs[4] = '{5, 2, 2, 10};
      vecs[5] = '{6, 2, 2, 11};
      vecs[6] = '{8, 3, 2, 13};

      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", {busy, done, fifo_pop, out_valid, out_last, out_data}, 0);
      rst_n = 1'b1;
      tick();

      for (int v = 0; v < 7; v++) begin
         flush();
         for (int j = 0; j < vecs[v].nwords; j++) push_word(seq_word(j));
         start_xfer(vecs[v].len);
         finish_xfer(0, 100, 1'b0);
         check_stream(vecs[v].len, 3, "vec");
         check("vec_pops_table", pop_cnt, vecs[v].exp_pops);
         check("vec_done_cycle", done_rel, vecs[v].exp_done);
         check("vec_first_valid", first_valid, (vecs[v].len == 0) ? -1 : 3);
      end

      flush();
      push_word(seq_word(0));
      start_xfer(4);
      finish_xfer(1, 200, 1'b0);
      check_stream(4, -1, "backpressure");

      flush();
      push_word(seq_word(0));
      push_word(seq_word(1));
      start_xfer(6);
      finish_xfer(0, 100, 1'b1);
      check_stream(6, 3, "busy_start");

      flush();
      start_xfer(4);
      out_ready = 1'b1;
      repeat (10) tick();
      check("stall_no_pop", pop_cnt, 0);
      check("stall_no_valid", first_valid, -1);
      check("stall_busy", busy, 1);
      push_word(seq_word(0));
      ne_rel = cyc - start_cyc;
      finish_xfer(0, 100, 1'b0);
      check("stall_pop_cycle", first_pop, ne_rel);
      check_stream(4, ne_rel + 2, "stall");

      flush();
      push_word(seq_word(0));
      push_word(seq_word(1));
      start_xfer(8);
      out_ready = 1'b0;
      k = 0;
      while (!out_valid && k < 20) begin
         tick();
         k++;
      end
      check("areset_reach_send", out_valid, 1);
      #1;
      rst_n = 1'b0;
      #1;
      check("areset_outputs", {busy, done, fifo_pop, out_valid, out_last, out_data}, 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check("areset_no_done", done_cnt, 0);
      check("areset_pops", pop_cnt, 1);
      check("areset_idle", busy, 0);
      void'(pushed.pop_front());
      start_xfer(2);
      finish_xfer(0, 100, 1'b0);
      check_stream(2, 3, "after_reset");

      flush();
      push_word(seq_word(0));
      start_xfer(4);
      out_ready = 1'b0;
      k = 0;
      while (!out_valid && k < 20) begin
         tick();
         k++;
      end
      check("sreset_reach_send", out_valid, 1);
      Reset = 1'b1;
      #1;
      check("sreset_waits_edge", busy, 1);
      tick();
      check("sreset_outputs", {busy, done, fifo_pop, out_valid, out_last, out_data}, 0);
      Reset = 1'b0;
      tick();
      tick();
      check("sreset_no_done", done_cnt, 0);

      for (int r = 0; r < 20; r++) begin
         flush();
         len = $urandom_range(0, 14);
         nw = (len + RATIO - 1) / RATIO + $urandom_range(0, 1);
         for (int j = 0; j < nw; j++) push_word({$urandom, $urandom});
         start_xfer(len);
         finish_xfer(2, 400, 1'b0);
         check_stream(len, -1, "random");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
      $fatal(1);
   end

endmodule
